// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the 16-bit, 32-GPR processor: instruction-register
// field positions, opcode values, flag bit indices and the sequencer state
// encoding.
// -----------------------------------------------------------------------------
package isa_pkg;

    // IR field positions
    localparam int OPER_MSB     = 31;
    localparam int OPER_LSB     = 27;
    localparam int RDST_MSB     = 26;
    localparam int RDST_LSB     = 22;
    localparam int RSRC1_MSB    = 21;
    localparam int RSRC1_LSB    = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RSRC2_MSB    = 15;
    localparam int RSRC2_LSB    = 11;
    localparam int ISRC_MSB     = 15;
    localparam int ISRC_LSB     = 0;

    // Flag bit indices within {sign, zero, overflow, carry}
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Datapath ops listed here are a subset; any value that is not a control
    // opcode is forwarded to the datapath unchanged.
    typedef enum logic [4:0] {
        OP_MOV  = 5'd0,
        OP_ADD  = 5'd1,
        OP_ADI  = 5'd2,
        OP_SUB  = 5'd3,
        OP_JMP  = 5'd16,
        OP_JC   = 5'd17,
        OP_JNC  = 5'd18,
        OP_JS   = 5'd19,
        OP_JNS  = 5'd20,
        OP_JZ   = 5'd21,
        OP_JNZ  = 5'd22,
        OP_JO   = 5'd23,
        OP_JNO  = 5'd24,
        OP_HALT = 5'd31
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } seq_state_e;

    function automatic logic [4:0] oper_type(input logic [31:0] instr);
        return instr[OPER_MSB:OPER_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
// Bundles the instruction-memory fetch handshake and the datapath issue
// handshake seen by the sequencer.
//   imem_req/imem_addr  -> fetch request and address (sequencer drives)
//   imem_valid/rdata    <- fetched instruction (memory drives)
//   ir/exec_en          -> current instruction and issue strobe
//   exec_done/flags_in  <- datapath completion and result flags
// master = sequencer side, slave = memory/datapath side.
// -----------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;
    logic [31:0]     ir;
    logic            exec_en;
    logic            exec_done;
    logic [3:0]      flags_in;

    modport master (
        output imem_req, imem_addr, ir, exec_en,
        input  imem_valid, imem_rdata, exec_done, flags_in
    );

    modport slave (
        input  imem_req, imem_addr, ir, exec_en,
        output imem_valid, imem_rdata, exec_done, flags_in
    );
endinterface

// File: rtl/branch_eval.sv
// -----------------------------------------------------------------------------
// branch_eval
// Combinational jump resolution.
//   opcode_i  : oper_type field of the current instruction
//   flags_i   : latched {sign, zero, overflow, carry}
//   is_jump_o : opcode is JMP or one of the conditional jumps
//   take_o    : jump is taken (always 0 for non-jumps)
// -----------------------------------------------------------------------------
module branch_eval
    import isa_pkg::*;
(
    input  logic [4:0] opcode_i,
    input  logic [3:0] flags_i,
    output logic       is_jump_o,
    output logic       take_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise
        // the unlisted opcodes would infer latches.
        is_jump_o = 1'b1;
        take_o    = 1'b0;
        case (opcode_i)
            OP_JMP:  take_o = 1'b1;
            OP_JC:   take_o =  flags_i[FLAG_C];
            OP_JNC:  take_o = ~flags_i[FLAG_C];
            OP_JS:   take_o =  flags_i[FLAG_S];
            OP_JNS:  take_o = ~flags_i[FLAG_S];
            OP_JZ:   take_o =  flags_i[FLAG_Z];
            OP_JNZ:  take_o = ~flags_i[FLAG_Z];
            OP_JO:   take_o =  flags_i[FLAG_V];
            OP_JNO:  take_o = ~flags_i[FLAG_V];
            default: is_jump_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Fetch/decode/issue controller. Fetches instructions into IR, issues
// datapath ops one at a time, latches returned flags and resolves jumps and
// HALT internally. Sole owner of PC and IR.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin execution at RESET_PC (IDLE or HALT only)
//   bus        : fetch + issue handshakes (master modport)
//   flags      : latched {sign, zero, overflow, carry}
//   pc         : program counter
//   busy       : not in IDLE/HALT
//   halted     : in HALT
//   err        : sticky execution timeout
// -----------------------------------------------------------------------------
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int              PC_W         = 8,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              EXEC_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_sequencer_if.master   bus,
    output logic [3:0]          flags,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic                halted,
    output logic                err
);

    localparam int              CNT_W    = $clog2(EXEC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(EXEC_TIMEOUT - 1);

    seq_state_e       state_q;
    logic [PC_W-1:0]  pc_q;
    logic [31:0]      ir_q;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             imem_req_q;
    logic             exec_en_q;
    logic             busy_q;
    logic             halted_q;

    logic [4:0]       opcode;
    logic             is_jump;
    logic             take;
    logic [PC_W-1:0]  pc_inc;

    assign opcode = oper_type(ir_q);
    assign pc_inc = pc_q + PC_W'(1);

    branch_eval u_branch_eval (
        .opcode_i  (opcode),
        .flags_i   (flags_q),
        .is_jump_o (is_jump),
        .take_o    (take)
    );

    // Outputs are set alongside each state transition so every strobe comes
    // straight from a flop and drops with the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            flags_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            imem_req_q <= 1'b0;
            exec_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every register updates
            // from the values held before this edge regardless of order.
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q       <= RESET_PC;
                        err_q      <= 1'b0;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_valid) begin
                        ir_q       <= bus.imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_HALT) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (is_jump) begin
                        pc_q       <= take ? ir_q[ISRC_LSB +: PC_W] : pc_inc;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else begin
                        exec_en_q <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    exec_en_q <= 1'b0;
                    cnt_q     <= '0;
                    // A completion in the issue cycle itself is accepted.
                    if (bus.exec_done) begin
                        flags_q    <= bus.flags_in;
                        pc_q       <= pc_inc;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.exec_done) begin
                        flags_q    <= bus.flags_in;
                        pc_q       <= pc_inc;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else if (cnt_q == TMO_LAST) begin
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc_q       <= RESET_PC;
                        err_q      <= 1'b0;
                        flags_q    <= '0;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        halted_q   <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                default: begin
                    imem_req_q <= 1'b0;
                    exec_en_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    halted_q   <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.ir        = ir_q;
    assign bus.exec_en   = exec_en_q;
    assign flags         = flags_q;
    assign pc            = pc_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign err           = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Drives instr_sequencer with an instruction memory and a datapath responder
// of random latency, then replays the logged fetches and issues against an
// instruction-level reference model of the program.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;
    import isa_pkg::*;

    localparam int TMO   = 15;
    localparam int NEVER = 100;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] flags;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       err;

    instr_sequencer_if #(.PC_W(8)) bus ();

    instr_sequencer #(.PC_W(8), .RESET_PC(8'h00), .EXEC_TIMEOUT(TMO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus),
        .flags  (flags),
        .pc     (pc),
        .busy   (busy),
        .halted (halted),
        .err    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [256];
    int          fmap [4];
    int          total, bad;
    int          cyc, fetch_left, dleft, halt_cyc;
    bit          fetch_active, start_now;
    int          lat_fixed, d_fixed, flags_force, never_at;
    bit          spur_en, noise_en;

    int          f_addr[$], f_start[$], f_lat[$], f_req[$];
    logic [31:0] exec_ir[$];
    int          exec_pc[$], exec_d[$], exec_cyc[$];
    logic [3:0]  exec_flags[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] jmp_w(input int op, input logic [15:0] isrc);
        return {5'(op), 11'($urandom), isrc};
    endfunction

    function automatic logic [31:0] dp_w(input int op);
        logic [26:0] rest;
        rest = 27'($urandom);
        return {5'(op), rest};
    endfunction

    // Jump condition from the opcode ordering: pairs (cond, !cond) over C, S, Z, O.
    function automatic bit model_take(input int op, input logic [3:0] f);
        int k;
        if (op == 16) return 1'b1;
        k = op - 17;
        return (k % 2 == 0) ? f[fmap[k/2]] : !f[fmap[k/2]];
    endfunction

    task automatic fill_halt();
        for (int a = 0; a < 256; a++) mem[a] = {5'd31, 27'($urandom)};
    endtask

    task automatic cfg(input int lat, input int d, input int ff, input bit spur,
                       input bit noise, input int nev);
        lat_fixed = lat; d_fixed = d; flags_force = ff;
        spur_en = spur; noise_en = noise; never_at = nev;
    endtask

    task automatic clear_logs();
        f_addr.delete(); f_start.delete(); f_lat.delete(); f_req.delete();
        exec_ir.delete(); exec_pc.delete(); exec_d.delete(); exec_cyc.delete();
        exec_flags.delete();
        halt_cyc = -1;
    endtask

    // One clock: observe DUT outputs at the falling edge, then drive inputs
    // for the next rising edge.
    task automatic tick();
        int d;
        @(negedge clk);
        cyc++;
        if (halted && halt_cyc < 0) halt_cyc = cyc;
        if (bus.imem_req) begin
            if (!fetch_active) begin
                fetch_active = 1'b1;
                fetch_left   = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
                f_addr.push_back(int'(bus.imem_addr));
                f_start.push_back(cyc);
                f_lat.push_back(fetch_left);
                f_req.push_back(0);
            end
            f_req[f_req.size()-1] = f_req[f_req.size()-1] + 1;
            if (fetch_left == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = mem[bus.imem_addr];
            end else begin
                bus.imem_valid = 1'b0;
                bus.imem_rdata = $urandom;
                fetch_left--;
            end
        end else begin
            fetch_active   = 1'b0;
            bus.imem_valid = spur_en && ($urandom_range(0, 1) == 1);
            bus.imem_rdata = $urandom;
        end

        bus.flags_in  = 4'($urandom);
        bus.exec_done = 1'b0;
        if (bus.exec_en) begin
            if (exec_ir.size() == never_at) d = NEVER;
            else if (d_fixed >= 0)          d = d_fixed;
            else                            d = $urandom_range(0, 4);
            exec_ir.push_back(bus.ir);
            exec_pc.push_back(int'(pc));
            exec_d.push_back(d);
            exec_cyc.push_back(cyc);
            exec_flags.push_back(4'h0);
            dleft = 0;
            if (d == 0) begin
                bus.exec_done = 1'b1;
                if (flags_force >= 0) bus.flags_in = 4'(flags_force);
                exec_flags[exec_flags.size()-1] = bus.flags_in;
            end else if (d < NEVER) begin
                dleft = d;
            end
        end else if (dleft > 0) begin
            dleft--;
            if (dleft == 0) begin
                bus.exec_done = 1'b1;
                if (flags_force >= 0) bus.flags_in = 4'(flags_force);
                exec_flags[exec_flags.size()-1] = bus.flags_in;
            end
        end else if (spur_en && bus.imem_req && ($urandom_range(0, 1) == 1)) begin
            bus.exec_done = 1'b1;
        end

        start     = start_now || (noise_en && busy && ($urandom_range(0, 3) == 0));
        start_now = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; start_now = 1'b0;
        bus.imem_valid = 1'b0; bus.imem_rdata = '0;
        bus.exec_done = 1'b0; bus.flags_in = '0;
        dleft = 0; fetch_active = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 8'h00);
        check("rst_ir", bus.ir, 32'h0);
        check("rst_flags", flags, 4'h0);
        check("rst_err", err, 1'b0);
        check("rst_strobes", {bus.imem_req, bus.exec_en, busy, halted}, 4'b0000);
        rst_n = 1'b1;
    endtask

    // Walk the program instruction by instruction and compare with the logs.
    task automatic replay(input string name);
        logic [7:0]  pcm;
        logic [3:0]  fm;
        logic [31:0] instr;
        int          ei, fi, op, lat, d, gap;
        bit          exp_err;
        pcm = 8'h00; fm = 4'h0; ei = 0; exp_err = 1'b0;
        for (fi = 0; fi < 300; fi++) begin
            if (fi >= f_addr.size()) begin
                check({name, "_fetch_missing"}, f_addr.size(), fi + 1);
                break;
            end
            check({name, "_fetch_addr"}, f_addr[fi], pcm);
            check({name, "_req_len"}, f_req[fi], f_lat[fi] + 1);
            instr = mem[pcm];
            op    = int'(instr[31:27]);
            lat   = f_lat[fi];
            if (op == 31) break;
            if (op >= 16 && op <= 24) begin
                gap = lat + 2;
                pcm = model_take(op, fm) ? instr[7:0] : pcm + 8'd1;
            end else begin
                if (ei >= exec_ir.size()) begin
                    check({name, "_exec_missing"}, exec_ir.size(), ei + 1);
                    break;
                end
                check({name, "_exec_ir"}, exec_ir[ei], instr);
                check({name, "_exec_pc"}, exec_pc[ei], pcm);
                d = exec_d[ei];
                ei++;
                if (d > TMO) begin
                    exp_err = 1'b1;
                    break;
                end
                fm  = exec_flags[ei-1];
                pcm = pcm + 8'd1;
                gap = lat + d + 3;
            end
            if (fi + 1 < f_start.size())
                check({name, "_gap"}, f_start[fi+1] - f_start[fi], gap);
        end
        check({name, "_fetch_cnt"}, f_addr.size(), fi + 1);
        check({name, "_exec_cnt"}, exec_ir.size(), ei);
        check({name, "_end_pc"}, pc, pcm);
        check({name, "_end_flags"}, flags, fm);
        check({name, "_end_state"}, {halted, busy, err}, {2'b10, exp_err});
    endtask

    task automatic run(input string name);
        int n;
        clear_logs();
        start_now = 1'b1;
        tick();
        tick();
        check({name, "_start_state"}, {bus.imem_req, busy, halted, err, bus.exec_en}, 5'b11000);
        check({name, "_start_pc"}, pc, 8'h00);
        check({name, "_start_flags"}, flags, 4'h0);
        halt_cyc = -1;
        n = 0;
        while (!halted && n < 3000) begin
            tick();
            n++;
        end
        if (!halted) check({name, "_halt_bound"}, 1'b0, 1'b1);
        replay(name);
    endtask

    logic [31:0] adi_w;

    initial begin
        total = 0; bad = 0; cyc = 0;
        fmap = '{0, 3, 2, 1};
        adi_w = {5'd2, 5'd0, 5'd2, 1'b1, 16'd4};
        cfg(0, 1, -1, 0, 0, -1);
        clear_logs();
        do_reset();

        // Single ADI, minimum latency
        fill_halt();
        mem[0] = adi_w;
        cfg(0, 1, -1, 0, 0, -1);
        run("adi");
        check("adi_ir", exec_ir[0], adi_w);
        check("adi_cycles", f_start[1] - f_start[0], 4);
        check("adi_pc", pc, 8'h01);

        // ADD then JZ, taken and not taken
        fill_halt();
        mem[0] = dp_w(1);
        mem[1] = jmp_w(21, 16'h0008);
        cfg(0, 1, 4'b0100, 0, 0, -1);
        run("jz_taken");
        check("jz_taken_target", f_addr[2], 8);
        cfg(0, 1, 4'b0000, 0, 0, -1);
        run("jz_not");
        check("jz_not_target", f_addr[2], 2);

        // JNC not taken with carry, JMP target truncation
        fill_halt();
        mem[0]     = dp_w(1);
        mem[1]     = jmp_w(16, 16'h0005);
        mem[5]     = jmp_w(18, 16'h0040);
        mem[6]     = jmp_w(16, 16'h01F3);
        cfg(-1, -1, 4'b0001, 0, 0, -1);
        run("jnc_jmp");
        check("jnc_next", f_addr[3], 6);
        check("jmp_trunc", pc, 8'hF3);

        // PC wrap after a datapath op at 0xFF
        fill_halt();
        mem[0]   = jmp_w(22, 16'h01FF);
        mem[255] = dp_w(3);
        cfg(-1, -1, 4'b0100, 0, 0, -1);
        run("wrap");
        check("wrap_ff", f_addr[1], 255);
        check("wrap_zero", f_addr[2], 0);

        // Slow fetch, spurious valid/done, start noise
        fill_halt();
        mem[0] = adi_w;
        cfg(3, 1, -1, 1, 1, -1);
        run("slow_fetch");
        check("slow_req_len", f_req[0], 4);

        // Completion on the last allowed WAIT cycle is accepted
        cfg(0, TMO, -1, 0, 0, -1);
        run("d_last");

        // Timeout, then restart clears err and flags
        fill_halt();
        mem[0] = dp_w(1);
        mem[1] = dp_w(2);
        cfg(-1, -1, 4'b1010, 0, 1, 1);
        run("timeout");
        check("timeout_wait_len", halt_cyc - exec_cyc[1], TMO + 1);
        cfg(-1, -1, 4'b1010, 0, 1, -1);
        run("restart");

        // HALT at pc=3 with start noise while busy
        do_reset();
        fill_halt();
        mem[0] = jmp_w(16, 16'h0003);
        mem[1] = dp_w(1);
        cfg(-1, -1, -1, 1, 1, -1);
        run("halt3");
        check("halt3_pc", pc, 8'h03);

        // Random forward-only programs
        for (int p = 0; p < 8; p++) begin
            int r, tgt;
            fill_halt();
            for (int a = 0; a < 20; a++) begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    r = $urandom_range(0, 21);
                    mem[a] = dp_w(r < 16 ? r : r + 9);
                end else if (r < 9) begin
                    tgt = $urandom_range(a + 1, 20);
                    mem[a] = jmp_w($urandom_range(16, 24), {8'($urandom), 8'(tgt)});
                end
            end
            if (p % 3 == 0) do_reset();
            cfg(-1, -1, -1, 1, 1, -1);
            run($sformatf("rand%0d", p));
        end

        // Asynchronous reset in the middle of WAIT
        do_reset();
        fill_halt();
        mem[0]  = jmp_w(16, 16'h0010);
        mem[16] = dp_w(1);
        cfg(0, -1, -1, 0, 0, 0);
        clear_logs();
        start_now = 1'b1;
        tick();
        for (int n = 0; n < 50 && exec_ir.size() == 0; n++) tick();
        repeat (3) tick();
        check("mid_wait_pre", {busy, pc}, {1'b1, 8'h10});
        #2 rst_n = 1'b0;
        #1;
        check("mid_wait_pc", pc, 8'h00);
        check("mid_wait_ir", bus.ir, 32'h0);
        check("mid_wait_out", {bus.imem_req, bus.exec_en, busy, halted, err}, 5'b00000);
        do_reset();

        // Asynchronous reset in the middle of a fetch
        cfg(10, 1, -1, 0, 0, -1);
        clear_logs();
        start_now = 1'b1;
        tick();
        repeat (3) tick();
        check("mid_fetch_pre", bus.imem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_fetch_req", {bus.imem_req, busy}, 2'b00);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/issue controller for the 16-bit, 32-GPR processor datapath.
- Fetches 32-bit instructions from instruction memory through a req/valid handshake and holds the current instruction in IR.
- Issues ALU/move instructions to the datapath one at a time, latches the returned flags, and resolves jump and halt instructions internally.
- Sits between imem and the datapath; it is the only writer of PC and IR.

Parameters:
- PC_W, 8, program counter / imem address width.
- RESET_PC, 0, PC value after reset and after start from HALT.
- EXEC_TIMEOUT, 15, max cycles waited for exec_done before declaring an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution from RESET_PC (honoured only in IDLE or HALT)
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  PC_W  fetch address (= PC)
- imem_valid  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction
- ir  out  32  current instruction to datapath
- exec_en  out  1  one-cycle issue strobe to datapath
- exec_done  in  1  datapath completion; flags valid this cycle
- flags_in  in  4  {sign, zero, overflow, carry} from datapath
- flags  out  4  latched flags
- pc  out  PC_W  current program counter
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- err  out  1  sticky exec timeout; cleared by start or reset

Behaviour:
- Reset (async, rst_n=0) puts the block in IDLE with pc=RESET_PC, ir=0, flags=0, err=0, and all strobes, busy and halted low.
- IR field layout (shared package):
  - oper_type [31:27]
  - rdst [26:22]
  - rsrc1 [21:17]
  - imm_mode [16]
  - rsrc2 [15:11]
  - isrc [15:0]
- Control opcodes (handled internally, never issued):
  - JMP=5'd16
  - JC=17, JNC=18
  - JS=19, JNS=20
  - JZ=21, JNZ=22
  - JO=23, JNO=24
  - HALT=5'd31
- Every other opcode is a datapath op.
- State machine:
  - IDLE: start moves to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - Stay until imem_valid=1.
    - On imem_valid, capture ir<=imem_rdata and go to DECODE.
    - imem_valid while imem_req=0 is ignored.
  - DECODE, datapath op: go to ISSUE.
  - DECODE, JMP or a jump whose condition on the latched flags is true: pc<=isrc[PC_W-1:0], go to FETCH.
  - DECODE, jump whose condition is false: pc<=pc+1, go to FETCH.
  - DECODE, HALT: go to HALT; pc is not incremented.
  - ISSUE: exec_en=1 for exactly one cycle, clear the timeout counter, go to WAIT.
  - WAIT, exec_done=1: flags<=flags_in, pc<=pc+1, go to FETCH.
    - exec_done asserted in the ISSUE cycle is also accepted; this gives minimum latency.
  - WAIT timeout: when the counter reaches EXEC_TIMEOUT with no exec_done, set err=1, flags unchanged, go to HALT.
  - HALT: halted=1. start sets pc<=RESET_PC, clears err and flags, and goes to FETCH.
- Minimum latency for a datapath op with 1-cycle exec_done: 4 cycles (FETCH, DECODE, ISSUE, WAIT), assuming imem_valid on the first FETCH cycle.
- Jump instructions take 2 cycles plus fetch time.
- pc increments modulo 2^PC_W: pc=2^PC_W-1 followed by +1 gives 0. The jump target is truncated to PC_W bits.
- start while busy is ignored. exec_done outside ISSUE/WAIT is ignored.
- Flags change only on an accepted exec_done (or are cleared by start from HALT). Jumps never modify flags.
- Reset mid-fetch or mid-exec aborts immediately; imem_req and exec_en drop asynchronously.

Decomposition:
- Package isa_pkg holds:
  - IR field position constants
  - opcode enum (datapath ops and control opcodes)
  - flag bit index constants
  - sequencer state enum
- Sub-module branch_eval (combinational: opcode plus flags gives take/not-take).
- The FSM, PC, IR and timeout counter stay in instr_sequencer.

Test Plan:
- Reset, then start. imem returns ADI (oper_type=2, imm_mode=1, rdst=0, rsrc1=2, isrc=4) with valid on the first req cycle, and exec_done one cycle after exec_en. Required response:
  - exactly one exec_en pulse
  - ir=that word
  - pc 0→1
  - 4 cycles total
- Program at 0: ADD whose datapath returns flags_in=4'b0100 (zero); 1: JZ isrc=8. Required response: fetch at 8 and no exec_en for the JZ. Same program with flags_in=0: fetch at 2.
- JNC at pc=5 with carry=1: pc=6. JMP isrc=16'h01F3 with PC_W=8: pc=8'hF3. Execute a datapath op at pc=8'hFF: next fetch at 0.
- imem_valid delayed 3 cycles: imem_req held high for 4 cycles, then drops. A spurious imem_valid in DECODE has no effect.
- exec_done never asserted: after 15 WAIT cycles err=1 and halted=1. Then start: err=0, flags=0, fetch at RESET_PC.
- HALT opcode at pc=3: halted=1, pc stays 3, start while busy is ignored. rst_n pulsed low mid-WAIT: all outputs return to reset values asynchronously.
